// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of a single-port memory.
// A master holds req until its transfer has happened. The granted master
// drives the memory combinationally. A burst counter limits a tenure to
// BURST transfers while the other master waits. A last-served pointer
// decides who wins when both masters request from idle.
module mem_arbiter #(
  parameter int N     = 8,   // data width
  parameter int AW    = 8,   // address width
  parameter int BURST = 4    // max transfers per tenure under contention (1..15)
) (
  input  logic          clk,
  input  logic          reset,        // synchronous, active-low
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [N-1:0]  wdata0,
  input  logic [N-1:0]  wdata1,
  input  logic          we0,
  input  logic          we1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [N-1:0]  rdata,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] mem_address,
  output logic [N-1:0]  mem_data_out,
  output logic          mem_write,
  input  logic [N-1:0]  mem_data_in
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G0   = 2'd1,
    S_G1   = 2'd2
  } state_t;

  // Counter value at which the current owner must hand over if the other
  // master is waiting; the counter also saturates here.
  localparam logic [3:0] CNT_MAX = 4'(BURST - 1);

  state_t        state_q,   state_d;
  logic [3:0]    cnt_q,     cnt_d;
  logic          ptr_q,     ptr_d;      // last master served (0 or 1)
  logic          gnt0_q,    gnt0_d;
  logic          gnt1_q,    gnt1_d;
  logic [N-1:0]  rdata_q,   rdata_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;

  logic          xfer0;
  logic          xfer1;

  // A transfer happens in any cycle where the granted master still requests.
  assign xfer0 = gnt0_q & req0;
  assign xfer1 = gnt1_q & req1;

  // Next-state, burst counter and last-served pointer.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;

    case (state_q)
      S_IDLE: begin
        if (req0 && req1) begin
          // Both waiting: serve the master that was not served last.
          state_d = ptr_q ? S_G0 : S_G1;
        end else if (req0) begin
          state_d = S_G0;
        end else if (req1) begin
          state_d = S_G1;
        end
      end
      S_G0: begin
        if (!req0) begin
          state_d = req1 ? S_G1 : S_IDLE;
        end else if (req1 && (cnt_q == CNT_MAX)) begin
          // Burst used up while master 1 waits: hand over after this transfer.
          state_d = S_G1;
        end
      end
      S_G1: begin
        if (!req1) begin
          state_d = req0 ? S_G0 : S_IDLE;
        end else if (req0 && (cnt_q == CNT_MAX)) begin
          state_d = S_G0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The counter restarts with every change of owner. Otherwise it counts
    // transfers and sticks at CNT_MAX, so a lone master keeps its grant
    // and gives it up at the first edge where the other master asks.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((xfer0 || xfer1) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end

    if (xfer0) begin
      ptr_d = 1'b0;
    end else if (xfer1) begin
      ptr_d = 1'b1;
    end

    // Grants are registered copies of the next state.
    gnt0_d = (state_d == S_G0);
    gnt1_d = (state_d == S_G1);
  end

  // Memory port: drive the granted master's request only while a transfer
  // is actually happening, otherwise hold the bus at zero.
  always_comb begin
    mem_address  = '0;
    mem_data_out = '0;
    mem_write    = 1'b0;
    if (xfer0) begin
      mem_address  = addr0;
      mem_data_out = wdata0;
      mem_write    = we0;
    end else if (xfer1) begin
      mem_address  = addr1;
      mem_data_out = wdata1;
      mem_write    = we1;
    end
  end

  // Read return: capture memory data on a read transfer; the valid bit
  // for that master lasts exactly one cycle.
  always_comb begin
    rvalid0_d = xfer0 & ~we0;
    rvalid1_d = xfer1 & ~we1;
    rdata_d   = rdata_q;
    if (rvalid0_d || rvalid1_d) begin
      rdata_d = mem_data_in;
    end
  end

  // State and output registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b1;        // master 0 wins the first contention
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rdata_q   <= rdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rdata   = rdata_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. The bench plays the memory.
// A reference model tracks who owns the bus, how long the current tenure
// has run, who was served last, and its own copy of the memory contents.
// Directed steps cover the documented scenarios; a random phase follows.
module tb_mem_arbiter;

  localparam int N     = 8;
  localparam int AW    = 8;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [N-1:0]  wdata0, wdata1;
  logic          we0, we1;
  logic          gnt0, gnt1;
  logic [N-1:0]  rdata;
  logic          rvalid0, rvalid1;
  logic [AW-1:0] mem_address;
  logic [N-1:0]  mem_data_out;
  logic          mem_write;
  logic [N-1:0]  mem_data_in;

  logic [N-1:0]  tb_mem  [0:255];   // memory seen by the DUT
  logic [N-1:0]  ref_mem [0:255];   // model's view of the memory

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int            m_owner;   // -1 = nobody, 0 or 1 = granted master
  int            m_run;     // transfers completed in the current tenure
  int            m_last;    // last master served
  logic          m_rv0, m_rv1;
  logic [N-1:0]  m_rdata;

  mem_arbiter #(.N(N), .AW(AW), .BURST(BURST)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .we0          (we0),
    .we1          (we1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rdata        (rdata),
    .rvalid0      (rvalid0),
    .rvalid1      (rvalid1),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_write    (mem_write),
    .mem_data_in  (mem_data_in)
  );

  always #5 clk = ~clk;

  assign mem_data_in = tb_mem[mem_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_run   = 0;
    m_last  = 1;
    m_rv0   = 1'b0;
    m_rv1   = 1'b0;
    m_rdata = '0;
  endtask

  // One clock cycle. Inputs are already applied. Check the outputs against
  // the model. Advance the model with this cycle's inputs. Act as the
  // memory at the rising edge. Return at the next falling edge.
  task automatic cyc();
    logic          x0, x1;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_data;
    logic          e_we;
    logic          wr_en;
    logic [AW-1:0] wr_a;
    logic [N-1:0]  wr_d;
    int            nxt, mine, oth;

    #1;
    x0 = (m_owner == 0) && req0;
    x1 = (m_owner == 1) && req1;
    e_addr = x0 ? addr0  : (x1 ? addr1  : '0);
    e_data = x0 ? wdata0 : (x1 ? wdata1 : '0);
    e_we   = x0 ? we0    : (x1 ? we1    : 1'b0);

    check("gnt0",         32'(gnt0),         32'(m_owner == 0));
    check("gnt1",         32'(gnt1),         32'(m_owner == 1));
    check("gnt_excl",     32'(gnt0 & gnt1),  32'd0);
    check("mem_address",  32'(mem_address),  32'(e_addr));
    check("mem_data_out", 32'(mem_data_out), 32'(e_data));
    check("mem_write",    32'(mem_write),    32'(e_we));
    check("rvalid0",      32'(rvalid0),      32'(m_rv0));
    check("rvalid1",      32'(rvalid1),      32'(m_rv1));
    check("rdata",        32'(rdata),        32'(m_rdata));

    wr_en = mem_write;
    wr_a  = mem_address;
    wr_d  = mem_data_out;

    // A write strobe that is present at the edge lands in memory even if
    // reset is asserted in the same cycle.
    if (reset) begin
      m_rv0 = x0 && !we0;
      m_rv1 = x1 && !we1;
      if (m_rv0) m_rdata = ref_mem[addr0];
      else if (m_rv1) m_rdata = ref_mem[addr1];
    end
    if (x0 && we0) ref_mem[addr0] = wdata0;
    if (x1 && we1) ref_mem[addr1] = wdata1;

    if (!reset) begin
      model_reset();
    end else begin
      if (x0) m_last = 0;
      if (x1) m_last = 1;
      if (m_owner < 0) begin
        if (req0 && req1) nxt = (m_last == 1) ? 0 : 1;
        else if (req0)    nxt = 0;
        else if (req1)    nxt = 1;
        else              nxt = -1;
      end else begin
        mine = (m_owner == 0) ? int'(req0) : int'(req1);
        oth  = (m_owner == 0) ? int'(req1) : int'(req0);
        if (mine == 0)                          nxt = (oth != 0) ? 1 - m_owner : -1;
        else if (oth != 0 && m_run + 1 >= BURST) nxt = 1 - m_owner;
        else                                     nxt = m_owner;
      end
      if (nxt != m_owner) m_run = 0;
      else if (x0 || x1)  m_run = m_run + 1;
      m_owner = nxt;
    end

    @(posedge clk);
    if (wr_en === 1'b1) tb_mem[wr_a] = wr_d;
    @(negedge clk);
  endtask

  initial begin
    reset  = 1'b0;
    req0   = 1'b0; req1   = 1'b0;
    addr0  = '0;   addr1  = '0;
    wdata0 = '0;   wdata1 = '0;
    we0    = 1'b0; we1    = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = N'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[5]  = 8'hA7;
    ref_mem[5] = 8'hA7;
    model_reset();

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_gnt0",    32'(gnt0),    32'd0);
    check("rst_gnt1",    32'(gnt1),    32'd0);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_rdata",   32'(rdata),   32'd0);
    cyc();
    reset = 1'b1;

    // Single read by master 0, issued right after reset release.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    cyc();
    #1;
    check("rd_gnt0", 32'(gnt0), 32'd1);
    check("rd_addr", 32'(mem_address), 32'h05);
    cyc();
    req0 = 1'b0;
    #1;
    check("rd_rdata",  32'(rdata),   32'hA7);
    check("rd_rvalid", 32'(rvalid0), 32'd1);
    cyc();
    #1;
    check("rd_rvalid_drop", 32'(rvalid0), 32'd0);
    cyc();

    // Single write by master 1.
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 8'h3C;
    cyc();
    #1;
    check("wr_gnt1",  32'(gnt1),         32'd1);
    check("wr_we",    32'(mem_write),    32'd1);
    check("wr_addr",  32'(mem_address),  32'h10);
    check("wr_data",  32'(mem_data_out), 32'h3C);
    cyc();
    req1 = 1'b0; we1 = 1'b0;
    #1;
    check("wr_no_rvalid", 32'(rvalid1), 32'd0);
    cyc();

    // Contention after reset: alternating bursts of 4, master 0 first.
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    cyc();
    for (int i = 0; i < 16; i++) begin
      #1;
      check("cont_gnt0", 32'(gnt0), 32'(((i / 4) % 2) == 0));
      check("cont_gnt1", 32'(gnt1), 32'(((i / 4) % 2) == 1));
      cyc();
    end

    // Solo hold: master 0 alone for 10 cycles, then master 1 takes over
    // at the very next edge because the counter is saturated.
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    cyc();
    req0 = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      #1;
      check("solo_gnt0", 32'(gnt0), 32'd1);
      cyc();
    end
    req1 = 1'b1;
    #1;
    check("solo_last_gnt0", 32'(gnt0), 32'd1);
    cyc();
    #1;
    check("solo_hand_gnt1", 32'(gnt1), 32'd1);
    check("solo_hand_gnt0", 32'(gnt0), 32'd0);
    cyc();

    // Release handover: master 0 drops req while master 1 waits.
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    cyc();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h22; wdata0 = 8'h5A;
    cyc();
    cyc();
    cyc();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h22;
    #1;
    check("rel_gnt0",   32'(gnt0),        32'd1);
    check("rel_nowr",   32'(mem_write),   32'd0);
    check("rel_noaddr", 32'(mem_address), 32'd0);
    cyc();
    #1;
    check("rel_gnt1", 32'(gnt1), 32'd1);
    cyc();
    req1 = 1'b0;
    #1;
    check("rel_rdata",  32'(rdata),   32'h5A);
    check("rel_rvalid", 32'(rvalid1), 32'd1);
    cyc();

    // Reset in the middle of a master 1 write burst.
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h30; wdata1 = 8'h77;
    cyc();
    cyc();
    #1;
    check("mid_wr_active", 32'(mem_write), 32'd1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0;
    #1;
    check("mid_gnt1",    32'(gnt1),      32'd0);
    check("mid_nowr",    32'(mem_write), 32'd0);
    check("mid_rvalid0", 32'(rvalid0),   32'd0);
    check("mid_rvalid1", 32'(rvalid1),   32'd0);
    cyc();
    #1;
    check("mid_first_gnt0", 32'(gnt0), 32'd1);
    check("mid_first_gnt1", 32'(gnt1), 32'd0);
    cyc();
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    cyc();

    // Random traffic with sticky requests and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) req1 = 1'($urandom_range(0, 1));
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      addr0  = AW'($urandom_range(0, 15));
      addr1  = AW'($urandom_range(0, 15));
      wdata0 = N'($urandom);
      wdata1 = N'($urandom);
      reset  = ($urandom_range(0, 63) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
